// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: owns the MIPS32 PC, selects the next PC each cycle and freezes
// the core in HALT/TRAP on break or fault.  Rev 1.0
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        dec_illegal,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_val,
  output logic        invpc,
  output logic        iOp,
  output logic [1:0]  state,
  output logic [2:0]  error,
  output logic [31:0] trap_pc
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_INVPC = 3'd1;
  localparam logic [2:0] ERR_ILLOP = 3'd2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;
  localparam logic [4:0] RA_REG  = 5'd31;

  // One bit wider than the PC so the window end cannot overflow.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IMEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  error_q, error_d;
  logic [31:0] trap_pc_q, trap_pc_d;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic        is_special;
  logic        is_jr;
  logic        is_jalr;
  logic        is_break;
  logic        is_j;
  logic        is_jal;
  logic        is_regimm;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        run_cycle;
  logic        unused_shamt;

  assign opcode     = instr[31:26];
  assign funct      = instr[5:0];
  assign rt_field   = instr[20:16];
  assign is_special = (opcode == OP_SPECIAL);
  assign is_jr      = is_special && (funct == FN_JR);
  assign is_jalr    = is_special && (funct == FN_JALR);
  assign is_break   = is_special && (funct == FN_BREAK);
  assign is_j       = (opcode == OP_J);
  assign is_jal     = (opcode == OP_JAL);
  assign is_regimm  = (opcode == OP_REGIMM);
  assign unused_shamt = &{1'b0, instr[10:6]};

  assign pc_plus4    = pc_q + 32'd4;
  assign br_target   = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};

  assign invpc = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || ({1'b0, pc_q} >= PC_LIMIT);
  assign iOp   = dec_illegal || (is_regimm && (rt_field != RT_BLTZ) && (rt_field != RT_BGEZ));

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BEQ:    br_taken = (rs_val == rt_val);
      OP_BNE:    br_taken = (rs_val != rt_val);
      OP_BLEZ:   br_taken = ($signed(rs_val) <= 0);
      OP_BGTZ:   br_taken = ($signed(rs_val) > 0);
      OP_REGIMM: br_taken = ((rt_field == RT_BLTZ) &&  rs_val[31]) ||
                            ((rt_field == RT_BGEZ) && !rs_val[31]);
      default:   br_taken = 1'b0;
    endcase
  end

  always_comb begin
    if (is_jr || is_jalr) begin
      next_pc = rs_val;
    end else if (is_j || is_jal) begin
      next_pc = jump_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

  assign run_cycle = (state_q == ST_RUN) && !stall;

  assign link_we   = (is_jal || is_jalr) && run_cycle && !reset && !invpc && !iOp;
  assign link_addr = is_jal ? RA_REG : instr[15:11];
  assign link_val  = pc_plus4;

  // Fault priority: bad PC beats illegal opcode beats break.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    error_d   = error_q;
    trap_pc_d = trap_pc_q;
    if (run_cycle) begin
      if (invpc) begin
        state_d   = ST_TRAP;
        error_d   = ERR_INVPC;
        trap_pc_d = pc_q;
      end else if (iOp) begin
        state_d   = ST_TRAP;
        error_d   = ERR_ILLOP;
        trap_pc_d = pc_q;
      end else if (is_break) begin
        state_d   = ST_HALT;
        trap_pc_d = pc_q;
      end else begin
        pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      error_q   <= ERR_NONE;
      trap_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      error_q   <= error_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign pc      = pc_q;
  assign state   = state_q;
  assign error   = error_q;
  assign trap_pc = trap_pc_q;

endmodule
`default_nettype wire
